// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus DataPath: fetch, decode on IR[31:27], execute.
// Memory states are stretched by MEM_WAIT cycles using a 3-bit down-counter reloaded on entry.
//
// state | meaning
// RST   | held in reset, all outputs 0
// T0    | PCout MARin IncPC; stop request here goes to HALT
// T1    | instruction read, held 1+MEM_WAIT cycles
// T2    | MDRout IRin
// T3-T7 | execute steps, decoded from the opcode
// HALT  | idle, run=0, left only through clear
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  ALU_ADD  = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        ZLOin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        R15in,
  output logic        read,
  output logic        write,
  output logic        RAMenable,
  output logic        conin,
  output logic        OutPortenable,
  output logic        PortInout,
  output logic [4:0]  aluControl
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;

  logic [4:0] opcode;
  logic       is_ralu, is_ialu, is_unary, is_ldi, is_ld, is_st, is_br;
  logic       is_jr, is_in, is_out, is_nop, is_addr, is_short;
  logic [4:0] ialu_code;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    is_ralu  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    is_ialu  = (opcode >= 5'b01100) && (opcode <= 5'b01110);
    is_unary = (opcode == 5'b10001) || (opcode == 5'b10010);
    is_ldi   = (opcode == 5'b00001);
    is_ld    = (opcode == 5'b00000);
    is_st    = (opcode == 5'b00010);
    is_br    = (opcode == 5'b10011);
    is_jr    = (opcode == 5'b10100);
    is_in    = (opcode == 5'b10110);
    is_out   = (opcode == 5'b10111);
    is_nop   = (opcode == 5'b11010);
    // ldi, ld and st share the base-plus-offset address computation in T3-T4
    is_addr  = is_ldi || is_ld || is_st;
    is_short = is_jr || is_in || is_out || is_nop;
    case (opcode)
      5'b01101: ialu_code = 5'b00101;
      5'b01110: ialu_code = 5'b00110;
      default:  ialu_code = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        if (stop) begin
          state_d = S_HALT;
        end else begin
          state_d = S_T1;
          wait_d  = WAIT_LOAD;
        end
      end
      S_T1: begin
        if (wait_q == 3'd0) state_d = S_T2;
        else                wait_d  = wait_q - 3'd1;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_short)                                   state_d = S_T0;
        else if (is_ralu || is_ialu || is_unary ||
                 is_addr || is_br)                      state_d = S_T4;
        else                                            state_d = S_HALT;
      end
      S_T4: state_d = is_unary ? S_T0 : S_T5;
      S_T5: begin
        if (is_ld || is_st || is_br) begin
          state_d = S_T6;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (is_ld) begin
          if (wait_q == 3'd0) state_d = S_T7;
          else                wait_d  = wait_q - 3'd1;
        end else if (is_st) begin
          state_d = S_T7;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (is_st && (wait_q != 3'd0)) wait_d  = wait_q - 3'd1;
        else                           state_d = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RST;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    run = (state_q != S_RST) && (state_q != S_HALT);
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Cout = 1'b0; BAout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    ZLOin = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0; R15in = 1'b0;
    read = 1'b0; write = 1'b0; RAMenable = 1'b0; conin = 1'b0;
    OutPortenable = 1'b0; PortInout = 1'b0; aluControl = 5'b00000;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_ralu || is_ialu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = opcode;
        end else if (is_addr) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; conin = 1'b1;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (is_in) begin
          Gra = 1'b1; Rin = 1'b1; PortInout = 1'b1;
        end else if (is_out) begin
          Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1;
        end
      end
      S_T4: begin
        if (is_ralu) begin
          Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = opcode;
        end else if (is_ialu) begin
          Cout = 1'b1; ZLOin = 1'b1; aluControl = ialu_code;
        end else if (is_unary) begin
          ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_addr) begin
          Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_ralu || is_ialu || is_ldi) begin
          ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_ld || is_st) begin
          ZLOout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD;
        end
      end
      S_T6: begin
        if (is_ld) begin
          read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          ZLOout = 1'b1; PCin = CON;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          write = 1'b1; RAMenable = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
